weight_buffer: RTL

Double-buffered kernel store sitting directly downstream of the weight BRAM loader. It drives the loader's `load_start`, `load_done` and `addr_rst` handshake and captures the 4-lane weight stream, `KERNEL_SIZE` beats per kernel, into one of two banks. It then presents a complete kernel to the PE array, holding it until the array acknowledges. The next kernel is prefetched into the free bank while the current one is in use.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/weight_bank.sv | 49 ++++
 rtl/weight_buffer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: default datapath sizes, the
// weight_buffer FSM state encoding and a small index-width helper.
package cnn_pkg;

    localparam int unsigned DEF_WEIGHT_WIDTH = 8;
    localparam int unsigned DEF_NUM_LANES    = 4;
    localparam int unsigned DEF_KERNEL_SIZE  = 9;
    localparam int unsigned DEF_KCNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } wb_state_e;

    // Bits needed to index n beats (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = (n > 1) ? int'($clog2(n)) : 1;
        return w;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One kernel bank: stores KERNEL_SIZE beats of four weight lanes.
// Ports:
//   clk, rst      clock, synchronous active-high clear of all contents
//   we, idx       write enable and beat index for the current beat
//   weight0..3    lane data for the beat (lane count is fixed at 4)
//   kernel_data   flat contents, lane L beat B at (L*KERNEL_SIZE+B)*WEIGHT_WIDTH
module weight_bank
    import cnn_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int unsigned NUM_LANES    = DEF_NUM_LANES,
    parameter int unsigned KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int unsigned IDX_W        = idx_width(KERNEL_SIZE)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        we,
    input  logic [IDX_W-1:0]                            idx,
    input  logic [WEIGHT_WIDTH-1:0]                     weight0,
    input  logic [WEIGHT_WIDTH-1:0]                     weight1,
    input  logic [WEIGHT_WIDTH-1:0]                     weight2,
    input  logic [WEIGHT_WIDTH-1:0]                     weight3,
    output logic [NUM_LANES*KERNEL_SIZE*WEIGHT_WIDTH-1:0] kernel_data
);

    localparam int unsigned KD_W = NUM_LANES * KERNEL_SIZE * WEIGHT_WIDTH;

    logic [WEIGHT_WIDTH-1:0] lane [4];
    logic [KD_W-1:0]         data;

    assign lane[0] = weight0;
    assign lane[1] = weight1;
    assign lane[2] = weight2;
    assign lane[3] = weight3;

    // Scatter one beat across the lane-major layout.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                data[(l * KERNEL_SIZE + int'(idx)) * WEIGHT_WIDTH +: WEIGHT_WIDTH] <= lane[l];
            end
        end
    end

    assign kernel_data = data;

endmodule

// File: rtl/weight_buffer.sv
// Double-buffered kernel store between the weight BRAM loader and the PE array.
// Requests kernels from the loader, captures KERNEL_SIZE beats of 4 lanes into
// the free bank, and presents the oldest complete bank until acknowledged.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   layer_start, num_kernels       begin a layer of num_kernels kernels (IDLE only)
//   load_start, load_done, addr_rst  loader handshake (load_done is combinational)
//   weight0..3, weight_vld         lane stream from the loader
//   kernel_data, kernel_vld        read bank contents and its full flag
//   kernel_ack                     PE array releases the current kernel
//   layer_done, busy               layer status
module weight_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int unsigned NUM_LANES    = DEF_NUM_LANES,
    parameter int unsigned KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int unsigned KCNT_W       = DEF_KCNT_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          layer_start,
    input  logic [KCNT_W-1:0]                             num_kernels,
    output logic                                          load_start,
    output logic                                          load_done,
    output logic                                          addr_rst,
    input  logic [WEIGHT_WIDTH-1:0]                       weight0,
    input  logic [WEIGHT_WIDTH-1:0]                       weight1,
    input  logic [WEIGHT_WIDTH-1:0]                       weight2,
    input  logic [WEIGHT_WIDTH-1:0]                       weight3,
    input  logic                                          weight_vld,
    output logic [NUM_LANES*KERNEL_SIZE*WEIGHT_WIDTH-1:0] kernel_data,
    output logic                                          kernel_vld,
    input  logic                                          kernel_ack,
    output logic                                          layer_done,
    output logic                                          busy
);

    localparam int unsigned KD_W  = NUM_LANES * KERNEL_SIZE * WEIGHT_WIDTH;
    localparam int unsigned IDX_W = idx_width(KERNEL_SIZE);

    wb_state_e         state, state_nx;
    logic              wr_bank, rd_bank;
    logic [1:0]        full, full_nx;
    logic [KCNT_W-1:0] remaining;
    logic [IDX_W-1:0]  bcnt;
    logic              layer_active;
    logic              start_c, beat_c, last_beat_c, ack_c;
    logic [KD_W-1:0]   bank0_data, bank1_data;

    assign start_c     = (state == ST_IDLE) && layer_start;
    assign beat_c      = (state == ST_FILL) && weight_vld;
    assign last_beat_c = beat_c && (bcnt == IDX_W'(KERNEL_SIZE - 1));
    assign ack_c       = kernel_ack && kernel_vld;

    // Loader stops incrementing one beat early; it still delivers the final beat.
    assign load_done   = beat_c && (bcnt == IDX_W'(KERNEL_SIZE - 2));

    assign kernel_vld  = full[rd_bank];
    assign busy        = (state != ST_IDLE) || (full != 2'b00);
    assign kernel_data = rd_bank ? bank1_data : bank0_data;

    weight_bank #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .NUM_LANES    (NUM_LANES),
        .KERNEL_SIZE  (KERNEL_SIZE),
        .IDX_W        (IDX_W)
    ) u_bank0 (
        .clk         (clk),
        .rst         (rst),
        .we          (beat_c && !wr_bank),
        .idx         (bcnt),
        .weight0     (weight0),
        .weight1     (weight1),
        .weight2     (weight2),
        .weight3     (weight3),
        .kernel_data (bank0_data)
    );

    weight_bank #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .NUM_LANES    (NUM_LANES),
        .KERNEL_SIZE  (KERNEL_SIZE),
        .IDX_W        (IDX_W)
    ) u_bank1 (
        .clk         (clk),
        .rst         (rst),
        .we          (beat_c && wr_bank),
        .idx         (bcnt),
        .weight0     (weight0),
        .weight1     (weight1),
        .weight2     (weight2),
        .weight3     (weight3),
        .kernel_data (bank1_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and next bank-full flags.
    always_comb begin
        state_nx = state;
        full_nx  = full;
        case (state)
            ST_IDLE: begin
                if (!layer_start && (remaining != '0) && !full[wr_bank]) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ:   state_nx = ST_FILL;
            ST_FILL: begin
                if (last_beat_c) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        // Ack and completion always target different banks, so both apply.
        if (ack_c) begin
            full_nx[rd_bank] = 1'b0;
        end
        if (last_beat_c) begin
            full_nx[wr_bank] = 1'b1;
        end
    end

    // Handshake outputs, pointers and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_rst     <= 1'b0;
            load_start   <= 1'b0;
            bcnt         <= '0;
            full         <= 2'b00;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            remaining    <= '0;
            layer_active <= 1'b0;
            layer_done   <= 1'b0;
        end else begin
            addr_rst   <= start_c;
            load_start <= (state == ST_REQ);
            if (state == ST_REQ) begin
                bcnt <= '0;
            end else if (beat_c) begin
                bcnt <= bcnt + IDX_W'(1);
            end
            if (start_c) begin
                // Pointers restart too, so a new layer always fills bank 0 first.
                full         <= 2'b00;
                wr_bank      <= 1'b0;
                rd_bank      <= 1'b0;
                remaining    <= num_kernels;
                layer_active <= 1'b1;
                layer_done   <= (num_kernels == '0);
            end else begin
                full <= full_nx;
                if (last_beat_c) begin
                    wr_bank   <= ~wr_bank;
                    remaining <= remaining - KCNT_W'(1);
                end
                if (ack_c) begin
                    rd_bank <= ~rd_bank;
                end
                if (layer_active && (state == ST_IDLE) && (remaining == '0) && (full == 2'b00)) begin
                    layer_done <= 1'b1;
                end
            end
        end
    end

endmodule
